mul_ctrl: RTL
=============

Name: mul_ctrl

Overview:
Front-end controller for the shared booth_mul datapath.
- Arbitrates between two requesters (req0 and req1) with round-robin priority.
- Decodes the RV64 M-extension multiply ops into booth_mul signedness, operand forms and result selection.
- Sequences one multiply at a time, holds the result until the consumer accepts it, and propagates pipeline flush.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to result.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  kill any in-flight operation
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW, others reserved
req0_a  in  64  operand rs1
req0_b  in  64  operand rs2
req0_tag  in  TAG_W  requester tag
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as req0, for requester 1
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_data  out  64  final rd value
out_tag  out  TAG_W  tag of the completed op
out_src  out  1  index of the requester that issued the op
m_valid  out  1  to booth_mul mul_valid
m_signed  out  2  to booth_mul mul_signed; bit1 = a signed, bit0 = b signed
m_a  out  64  to booth_mul mul_a
m_b  out  64  to booth_mul mul_b
m_flush  out  1  to booth_mul mul_flush
m_o_ready  out  1  to booth_mul mul_o_ready
m_o_valid  in  1  from booth_mul mul_o_valid
m_hi  in  64  from booth_mul mul_result_hi
m_lo  in  64  from booth_mul mul_result_lo

Behaviour:
- Reset: state = IDLE, rr_last = 1 (so req0 wins first), all outputs 0, operand/result registers 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if flush is low and a request is valid, grant it.
    - If both requesters are valid, the one not equal to rr_last wins.
    - reqN_ready = 1 for the granted requester only, combinational and same cycle.
    - Latch op, a, b, tag, src; update rr_last; go to ISSUE.
  - ISSUE: m_valid = 1 for exactly one cycle; m_a, m_b and m_signed are registered and stable from ISSUE until leaving WAIT; go to WAIT.
  - WAIT: m_o_ready = 1. On m_o_valid, capture out_data from m_hi/m_lo and go to DONE. booth_mul latency may be any N ≥ 1.
  - DONE: out_valid = 1; out_data, out_tag and out_src are stable. When out_ready = 1, go to IDLE. No new grant is made in the same cycle.
- Decode:
  - MUL: signed = 11, result = lo.
  - MULH: signed = 11, result = hi.
  - MULHSU: signed = 10, result = hi.
  - MULHU: signed = 00, result = hi.
  - MULW: a and b are sign-extended from bit 31, signed = 11, result = sext(lo[31:0]).
  - Reserved op: accepted, no multiply issued (ISSUE/WAIT skipped, IDLE goes straight to DONE), out_data = 0.
- Flush:
  - m_flush = flush (combinational).
  - In any state, flush forces IDLE next cycle and out_valid drops.
  - While flush is high, no grant is made.
  - A m_o_valid arriving in the same cycle as flush is discarded.
- Throughput: at most one op in flight; both reqN_ready are 0 outside IDLE.

Optional Feature:
MUL_CTRL_RESULT_CACHE_EN
- With the macro: keep the last completed {a, b, signed, hi, lo} plus a cache_vld bit.
  - cache_vld is cleared by reset and by flush.
  - A granted op whose post-decode a, b and signed match the cache goes IDLE to DONE in one cycle, with no m_valid.
  - This lets a MULH followed by MUL on the same operands complete without engaging the multiplier.
- Without the macro: every non-reserved op passes through ISSUE and WAIT.

Decomposition:
- Package mul_ctrl_pkg holds:
  - op encodings (MUL_OP_*);
  - state encodings;
  - the signedness constants SGN_SS = 11, SGN_SU = 10, SGN_UU = 00.
- One sub-module, mul_rr_arb2: 2-input round-robin arbiter taking valid0, valid1, en and rr_last, returning the grant and grant index.

Test Plan:
1. req0 MULH, a = b = 0xFFFF_FFFF_FFFF_FFFF, booth_mul latency 5 → exactly one m_valid pulse with m_signed = 11; out_data = 0x0; out_tag equals the request tag; out_src = 0.
2. req1 MULHU with the same operands → m_signed = 00; out_data = 0xFFFF_FFFF_FFFF_FFFE. Then MULHSU, a = all-ones, b = 2 → m_signed = 10; out_data = 0xFFFF_FFFF_FFFF_FFFF.
3. MULW, a = 0x0000_0000_7FFF_FFFF, b = 2 → out_data = 0xFFFF_FFFF_FFFF_FFFE. Then a = 0xDEAD_BEEF_0000_0003, b = 5 → m_a = 0x3, out_data = 0xF.
4. req0 and req1 both held valid for 4 ops → grant order 0, 1, 0, 1; the non-granted ready stays 0; out_src follows the grant order.
5. flush asserted in WAIT while m_o_valid also arrives that cycle → m_flush is high the same cycle, no out_valid is produced, state returns to IDLE, and the next request completes normally. Also hold out_ready = 0 for 3 cycles in DONE → out_data is stable throughout.
6. With MUL_CTRL_RESULT_CACHE_EN: MULH then MUL with identical operands → the second op produces no m_valid and out_valid rises 1 cycle after grant. After a flush, the same pair uses the multiplier for both ops.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the mul_ctrl front-end: op encodings, FSM states,
// signedness constants and the op decode / result select helpers.
package mul_ctrl_pkg;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;
    localparam logic [2:0] MUL_OP_MULW   = 3'b100;

    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } mul_state_t;

    typedef enum logic [1:0] {
        RES_LO,
        RES_HI,
        RES_W,
        RES_ZERO
    } res_sel_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  sgn;
        res_sel_t    sel;
        logic        rsvd;
    } mul_dec_t;

    function automatic mul_dec_t mul_decode(input logic [2:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        mul_dec_t d;
        d.a    = a;
        d.b    = b;
        d.sgn  = SGN_SS;
        d.sel  = RES_LO;
        d.rsvd = 1'b0;
        case (op)
            MUL_OP_MUL:    d.sel = RES_LO;
            MUL_OP_MULH:   d.sel = RES_HI;
            MUL_OP_MULHSU: begin d.sgn = SGN_SU; d.sel = RES_HI; end
            MUL_OP_MULHU:  begin d.sgn = SGN_UU; d.sel = RES_HI; end
            MUL_OP_MULW: begin
                d.a   = {{32{a[31]}}, a[31:0]};
                d.b   = {{32{b[31]}}, b[31:0]};
                d.sel = RES_W;
            end
            default: begin
                d.sel  = RES_ZERO;
                d.rsvd = 1'b1;
            end
        endcase
        return d;
    endfunction

    function automatic logic [63:0] res_select(input res_sel_t sel,
                                               input logic [63:0] hi,
                                               input logic [63:0] lo);
        logic [63:0] r;
        case (sel)
            RES_LO:  r = lo;
            RES_HI:  r = hi;
            RES_W:   r = {{32{lo[31]}}, lo[31:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-input round-robin arbiter: on contention the requester that did not
// win last time (rr_last) is granted.
module mul_rr_arb2
    import mul_ctrl_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       en,
    input  logic       rr_last,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant     = '0;
        grant_idx = 1'b0;
        if (en && (valid0 || valid1)) begin
            grant_idx = (valid0 && valid1) ? ~rr_last : valid1;
            grant     = grant_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// Front-end controller for the shared booth_mul datapath: arbitration, op
// decode, one-at-a-time sequencing and flush. Optional MUL_CTRL_RESULT_CACHE_EN.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src,
    output logic             m_valid,
    output logic [1:0]       m_signed,
    output logic [63:0]      m_a,
    output logic [63:0]      m_b,
    output logic             m_flush,
    output logic             m_o_ready,
    input  logic             m_o_valid,
    input  logic [63:0]      m_hi,
    input  logic [63:0]      m_lo
);

    mul_state_t       state, state_nxt;
    logic             rr_last;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic             gnt_any;
    logic [2:0]       sel_op;
    logic [63:0]      sel_a, sel_b;
    logic [TAG_W-1:0] sel_tag;
    mul_dec_t         dec;
    res_sel_t         res_sel;
    logic             cache_hit;
    logic [63:0]      hit_data;

    mul_rr_arb2 u_arb (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .en        ((state == ST_IDLE) && !flush && !rst),
        .rr_last   (rr_last),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign gnt_any    = |gnt;
    assign m_flush    = flush;

    always_comb begin
        sel_op  = gnt_idx ? req1_op  : req0_op;
        sel_a   = gnt_idx ? req1_a   : req0_a;
        sel_b   = gnt_idx ? req1_b   : req0_b;
        sel_tag = gnt_idx ? req1_tag : req0_tag;
    end

    assign dec = mul_decode(sel_op, sel_a, sel_b);

`ifdef MUL_CTRL_RESULT_CACHE_EN
    logic        cache_vld;
    logic [63:0] cache_a, cache_b, cache_hi, cache_lo;
    logic [1:0]  cache_sgn;

    // Match on post-decode operands so MULW and full-width ops never alias.
    assign cache_hit = cache_vld && !dec.rsvd && (dec.a == cache_a) &&
                       (dec.b == cache_b) && (dec.sgn == cache_sgn);
    assign hit_data  = res_select(dec.sel, cache_hi, cache_lo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld <= 1'b0;
            cache_a   <= '0;
            cache_b   <= '0;
            cache_sgn <= '0;
            cache_hi  <= '0;
            cache_lo  <= '0;
        end else if (flush) begin
            cache_vld <= 1'b0;
        end else if ((state == ST_WAIT) && m_o_valid) begin
            cache_vld <= 1'b1;
            cache_a   <= m_a;
            cache_b   <= m_b;
            cache_sgn <= m_signed;
            cache_hi  <= m_hi;
            cache_lo  <= m_lo;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        m_o_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_nxt = (dec.rsvd || cache_hit) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_valid   = !flush;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                m_o_ready = 1'b1;
                if (m_o_valid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last  <= 1'b1;
            m_a      <= '0;
            m_b      <= '0;
            m_signed <= '0;
            res_sel  <= RES_LO;
            out_data <= '0;
            out_tag  <= '0;
            out_src  <= 1'b0;
        end else begin
            if (gnt_any) begin
                rr_last  <= gnt_idx;
                m_a      <= dec.a;
                m_b      <= dec.b;
                m_signed <= dec.sgn;
                res_sel  <= dec.sel;
                out_tag  <= sel_tag;
                out_src  <= gnt_idx;
                if (dec.rsvd) begin
                    out_data <= '0;
                end else if (cache_hit) begin
                    out_data <= hit_data;
                end
            end
            if ((state == ST_WAIT) && m_o_valid && !flush) begin
                out_data <= res_select(res_sel, m_hi, m_lo);
            end
        end
    end

endmodule
